// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter : round-robin write-back arbiter with busy scoreboard
// Revision 1.0
// ============================================================================
module regfile_wb_arbiter #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int NUM_REGS     = 32,
  parameter int NUM_REQ      = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*REG_ADDR_LEN-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]        req_data,
  input  logic [NUM_REQ*2-1:0]            req_mode,
  input  logic                            mark_valid,
  input  logic [REG_ADDR_LEN-1:0]         mark_addr,
  input  logic [REG_ADDR_LEN-1:0]         srcA_addr,
  input  logic [REG_ADDR_LEN-1:0]         srcB_addr,
  input  logic [REG_ADDR_LEN-1:0]         dst_addr,
  output logic                            hazard,
  output logic                            wb_en,
  output logic [REG_ADDR_LEN-1:0]         wb_addr,
  output logic [WIDTH-1:0]                wb_data,
  output logic [1:0]                      wb_mode,
  input  logic                            halt,
  output logic                            halted
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REGS-1:0]     busy_q, busy_d;
  logic                    wb_en_q, wb_en_d;
  logic [REG_ADDR_LEN-1:0] wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0]        wb_data_q, wb_data_d;
  logic [1:0]              wb_mode_q, wb_mode_d;

  logic [REG_ADDR_LEN-1:0] addr_arr [NUM_REQ];
  logic [WIDTH-1:0]        data_arr [NUM_REQ];
  logic [1:0]              mode_arr [NUM_REQ];

  logic                    gnt_vld;
  logic [PTR_W-1:0]        gnt_idx;
  logic [REG_ADDR_LEN-1:0] sel_addr;
  logic [WIDTH-1:0]        sel_data;
  logic [1:0]              sel_mode;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*REG_ADDR_LEN +: REG_ADDR_LEN];
    assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
    assign mode_arr[i] = req_mode[i*2 +: 2];
  end

  // Grants only in RUN with halt low, so the halt-sampling cycle never hands off.
  always_comb begin : p_arb
    logic [PTR_W:0] sum;
    req_ready = '0;
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    if (state_q == RUN && !halt && rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
        if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
        if (!gnt_vld && req_valid[sum[PTR_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = sum[PTR_W-1:0];
        end
      end
    end
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  assign sel_addr = addr_arr[gnt_idx];
  assign sel_data = data_arr[gnt_idx];
  assign sel_mode = mode_arr[gnt_idx];

  always_comb begin : p_next
    rr_ptr_d  = rr_ptr_q;
    busy_d    = busy_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wb_mode_d = wb_mode_q;
    if (gnt_vld) begin
      rr_ptr_d         = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      busy_d[sel_addr] = 1'b0;
      // r0 is hardwired: the slot is consumed but nothing reaches the register file.
      if (sel_addr != '0) begin
        wb_en_d   = 1'b1;
        wb_addr_d = sel_addr;
        wb_data_d = sel_data;
        wb_mode_d = (sel_mode == 2'd3) ? 2'd0 : sel_mode;
      end
    end
    if (mark_valid && mark_addr != '0) busy_d[mark_addr] = 1'b1;
  end

  always_comb begin : p_fsm
    state_d = state_q;
    case (state_q)
      RUN:     if (halt) state_d = DRAIN;
      DRAIN: begin
        if (!halt)         state_d = RUN;
        else if (!wb_en_q) state_d = HALTED;
      end
      HALTED:  if (!halt) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      rr_ptr_q  <= '0;
      busy_q    <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_mode_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      busy_q    <= busy_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      wb_mode_q <= wb_mode_d;
    end
  end

  assign hazard  = busy_q[srcA_addr] | busy_q[srcB_addr] | busy_q[dst_addr];
  assign wb_en   = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign wb_mode = wb_mode_q;
  assign halted  = (state_q == HALTED);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_arbiter : directed bench with write-back scoreboard
// Revision 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int W  = 32;
  localparam int AL = 5;
  localparam int NR = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR*AL-1:0] req_addr;
  logic [NR*W-1:0]  req_data;
  logic [NR*2-1:0]  req_mode;
  logic          mark_valid;
  logic [AL-1:0] mark_addr, srcA_addr, srcB_addr, dst_addr;
  logic          hazard, wb_en, halt, halted;
  logic [AL-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic [1:0]    wb_mode;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.WIDTH(W), .REG_ADDR_LEN(AL), .NUM_REGS(32), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_mode(req_mode),
    .mark_valid(mark_valid), .mark_addr(mark_addr),
    .srcA_addr(srcA_addr), .srcB_addr(srcB_addr), .dst_addr(dst_addr),
    .hazard(hazard), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_mode(wb_mode), .halt(halt), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AL-1:0] a, input logic [W-1:0] d,
                         input logic [1:0] m);
    req_addr[i*AL +: AL] = a;
    req_data[i*W +: W]   = d;
    req_mode[i*2 +: 2]   = m;
  endtask

  // Reference model: evaluated at every falling edge, stepped with the inputs
  // that will be sampled at the following rising edge.
  typedef struct packed {
    logic [AL-1:0] a;
    logic [W-1:0]  d;
    logic [1:0]    m;
  } wb_t;

  wb_t         exp_q[$];
  logic [31:0] m_busy = '0;
  int          m_rr = 0;
  int          m_state = 0;
  bit          m_pend = 0;
  bit          m_live = 0;

  always @(negedge clk) begin
    int   gi;
    logic [NR-1:0] exp_rdy;
    wb_t  e;
    logic [AL-1:0] a;
    bit   old_pend;
    gi = -1;
    exp_rdy = '0;
    if (m_state == 0 && !halt && rst_n)
      for (int k = 0; k < NR; k++)
        if (gi < 0 && req_valid[(m_rr + k) % NR]) gi = (m_rr + k) % NR;
    if (gi >= 0) exp_rdy[gi] = 1'b1;
    if (m_live) begin
      check("m_ready", 64'(req_ready), 64'(exp_rdy));
      check("m_hazard", 64'(hazard),
            64'(m_busy[srcA_addr] | m_busy[srcB_addr] | m_busy[dst_addr]));
      check("m_halted", 64'(halted), 64'(m_state == 2));
      check("m_wb_en", 64'(wb_en), 64'(m_pend));
      if (m_pend && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_addr", 64'(wb_addr), 64'(e.a));
        check("sb_data", 64'(wb_data), 64'(e.d));
        check("sb_mode", 64'(wb_mode), 64'(e.m));
      end
    end
    if (!rst_n) begin
      m_busy = '0; m_rr = 0; m_state = 0; m_pend = 0; exp_q.delete(); m_live = 1;
    end else begin
      old_pend = m_pend;
      m_pend = 0;
      if (gi >= 0) begin
        m_rr = (gi + 1) % NR;
        a = req_addr[gi*AL +: AL];
        m_busy[a] = 1'b0;
        if (a != 0) begin
          e.a = a;
          e.d = req_data[gi*W +: W];
          e.m = (req_mode[gi*2 +: 2] == 2'd3) ? 2'd0 : req_mode[gi*2 +: 2];
          exp_q.push_back(e);
          m_pend = 1;
        end
      end
      if (mark_valid && mark_addr != 0) m_busy[mark_addr] = 1'b1;
      case (m_state)
        0: if (halt) m_state = 1;
        1: if (!halt) m_state = 0; else if (!old_pend) m_state = 2;
        default: if (!halt) m_state = 0;
      endcase
    end
  end

  initial begin
    int order [6];
    order = '{1, 2, 0, 1, 2, 0};
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; req_mode = '0;
    mark_valid = 1'b0; mark_addr = '0; srcA_addr = '0; srcB_addr = '0; dst_addr = '0;
    halt = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_wb_en", 64'(wb_en), 64'd0);
    check("rst_wb_addr", 64'(wb_addr), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    check("rst_wb_mode", 64'(wb_mode), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);

    // Single ALU write
    tick();
    req_valid = 3'b001; set_req(0, 5'd5, 32'hDEADBEEF, 2'd0);
    @(negedge clk);
    check("alu_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("alu_wb_en", 64'(wb_en), 64'd1);
    check("alu_wb_addr", 64'(wb_addr), 64'd5);
    check("alu_wb_data", 64'(wb_data), 64'hDEADBEEF);
    check("alu_wb_mode", 64'(wb_mode), 64'd0);
    tick();
    @(negedge clk);
    check("idle_wb_en", 64'(wb_en), 64'd0);
    check("hold_wb_addr", 64'(wb_addr), 64'd5);

    // All three contend; pointer sits at LSU after the ALU grant
    tick();
    for (int i = 0; i < NR; i++) set_req(i, AL'(10 + i), 32'hA000_0000 + W'(i), 2'(i));
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_grant", 64'(req_ready), 64'(1 << order[k]));
      if (k > 0) check("rr_b2b_wb_en", 64'(wb_en), 64'd1);
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    check("rr_last_wb_en", 64'(wb_en), 64'd1);

    // Scoreboard: mark r7, clear via LSU, then mark+clear in one cycle
    tick();
    mark_valid = 1'b1; mark_addr = 5'd7; srcA_addr = 5'd7;
    @(negedge clk);
    check("haz_no_bypass_set", 64'(hazard), 64'd0);
    tick();
    mark_valid = 1'b0;
    @(negedge clk);
    check("haz_set", 64'(hazard), 64'd1);
    tick();
    req_valid = 3'b010; set_req(1, 5'd7, 32'h0000_0077, 2'd1);
    @(negedge clk);
    check("haz_lsu_ready", 64'(req_ready), 64'b010);
    check("haz_no_bypass_clr", 64'(hazard), 64'd1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("haz_cleared", 64'(hazard), 64'd0);
    tick();
    mark_valid = 1'b1; req_valid = 3'b010;
    @(negedge clk);
    check("haz_mc_ready", 64'(req_ready), 64'b010);
    tick();
    mark_valid = 1'b0; req_valid = '0;
    @(negedge clk);
    check("haz_set_wins", 64'(hazard), 64'd1);
    tick();
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    @(negedge clk);
    check("haz_final_clear", 64'(hazard), 64'd0);

    // r0 writes and r0 marks are discarded; mode 3 forwards as word
    tick();
    req_valid = 3'b100; set_req(2, 5'd0, 32'h0000_1234, 2'd2);
    srcA_addr = 5'd0; mark_valid = 1'b1; mark_addr = 5'd0;
    @(negedge clk);
    check("r0_ready", 64'(req_ready), 64'b100);
    tick();
    req_valid = '0; mark_valid = 1'b0;
    @(negedge clk);
    check("r0_wb_en", 64'(wb_en), 64'd0);
    check("r0_busy", 64'(hazard), 64'd0);
    tick();
    req_valid = 3'b100; set_req(2, 5'd3, 32'h0000_0033, 2'd3);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("m3_wb_en", 64'(wb_en), 64'd1);
    check("m3_wb_addr", 64'(wb_addr), 64'd3);
    check("m3_wb_mode", 64'(wb_mode), 64'd0);

    // Halt with ALU and LSU pending; pointer at ALU after MUL grant
    tick();
    req_valid = 3'b011;
    set_req(0, 5'd1, 32'h1111_1111, 2'd0);
    set_req(1, 5'd2, 32'h2222_2222, 2'd0);
    @(negedge clk);
    check("halt_pre_grant", 64'(req_ready), 64'b001);
    tick();
    halt = 1'b1;
    @(negedge clk);
    check("halt_no_grant", 64'(req_ready), 64'b000);
    check("halt_pending_wb", 64'(wb_en), 64'd1);
    check("halt_not_yet", 64'(halted), 64'd0);
    tick();
    @(negedge clk);
    check("drain_halted", 64'(halted), 64'd0);
    tick();
    @(negedge clk);
    check("halted_set", 64'(halted), 64'd1);
    check("halted_no_grant", 64'(req_ready), 64'b000);
    tick();
    halt = 1'b0;
    @(negedge clk);
    check("halted_still", 64'(halted), 64'd1);
    tick();
    @(negedge clk);
    check("resume_grant", 64'(req_ready), 64'b010);
    check("resume_halted", 64'(halted), 64'd0);

    // Reset while a write is in flight and r9 is busy
    tick();
    req_valid = 3'b001; set_req(0, 5'd4, 32'h4444_4444, 2'd0);
    mark_valid = 1'b1; mark_addr = 5'd9;
    tick();
    req_valid = 3'b010; set_req(1, 5'd8, 32'h8888_8888, 2'd0);
    mark_valid = 1'b0; srcA_addr = 5'd9; rst_n = 1'b0;
    @(negedge clk);
    check("prerst_wb_en", 64'(wb_en), 64'd1);
    check("prerst_hazard", 64'(hazard), 64'd1);
    tick();
    rst_n = 1'b1; req_valid = 3'b111;
    @(negedge clk);
    check("postrst_wb_en", 64'(wb_en), 64'd0);
    check("postrst_hazard", 64'(hazard), 64'd0);
    check("postrst_rr", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
